// File: rtl/regfile_mp_bypass_if.sv
// Decode/writeback bundle for regfile_mp_bypass: two retire write lanes, NRD read ports, scoreboard claim.
// Combinational read side; no handshake or backpressure, every field is sampled or produced each cycle.
interface regfile_mp_bypass_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 3
);
    logic                     we0;
    logic [ADDR_W-1:0]        wa0;
    logic [DATA_W-1:0]        wd0;
    logic                     we1;
    logic [ADDR_W-1:0]        wa1;
    logic [DATA_W-1:0]        wd1;
    logic [NRD*ADDR_W-1:0]    ra;
    logic [NRD*DATA_W-1:0]    rd;
    logic [NRD-1:0]           rd_busy;
    logic                     sb_set;
    logic [ADDR_W-1:0]        sb_addr;
    logic [(2**ADDR_W)-1:0]   busy_vec;

    modport master (
        output we0, wa0, wd0, we1, wa1, wd1, ra, sb_set, sb_addr,
        input  rd, rd_busy, busy_vec
    );

    modport slave (
        input  we0, wa0, wd0, we1, wa1, wd1, ra, sb_set, sb_addr,
        output rd, rd_busy, busy_vec
    );
endinterface

// File: rtl/regfile_mp_bypass.sv
// Multi-port register file with two prioritised write lanes, same-cycle write bypass and a busy scoreboard.
// Reads are combinational (zero latency), writes/scoreboard update at the edge; no backpressure.
module regfile_mp_bypass #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NRD     = 3,
    parameter int ZERO_R0 = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_mp_bypass_if.slave   bus
);
    localparam int   DEPTH = 2**ADDR_W;
    localparam logic ZR    = (ZERO_R0 != 0);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_nxt;
    logic [NRD*DATA_W-1:0] rd_all;
    logic [NRD-1:0]        rd_busy_all;
    logic [ADDR_W-1:0]     a;
    logic [DATA_W-1:0]     d;
    logic                  hit0;
    logic                  hit1;
    logic                  clr;
    logic                  set;

    // A newly issued producer (set) outranks a retiring one (clr) on the same register.
    always_comb begin
        busy_nxt = '0;
        clr      = 1'b0;
        set      = 1'b0;
        for (int n = 0; n < DEPTH; n++) begin
            clr = (bus.we0 && bus.wa0 == ADDR_W'(n)) || (bus.we1 && bus.wa1 == ADDR_W'(n));
            set = bus.sb_set && bus.sb_addr == ADDR_W'(n);
            busy_nxt[n] = set || (busy[n] && !clr);
        end
        if (ZR) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < DEPTH; n++) begin
                mem[n] <= '0;
            end
            busy <= '0;
        end else begin
            if (bus.we0 && !(ZR && bus.wa0 == '0)) begin
                mem[bus.wa0] <= bus.wd0;
            end
            // Lane 1 is written last so it wins an address collision.
            if (bus.we1 && !(ZR && bus.wa1 == '0)) begin
                mem[bus.wa1] <= bus.wd1;
            end
            busy <= busy_nxt;
        end
    end

    always_comb begin
        rd_all      = '0;
        rd_busy_all = '0;
        a           = '0;
        d           = '0;
        hit0        = 1'b0;
        hit1        = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            a    = bus.ra[i*ADDR_W +: ADDR_W];
            hit1 = bus.we1 && bus.wa1 == a;
            hit0 = bus.we0 && bus.wa0 == a;
            if (ZR && a == '0) begin
                d = '0;
            end else if (hit1) begin
                d = bus.wd1;
            end else if (hit0) begin
                d = bus.wd0;
            end else begin
                d = mem[a];
            end
            rd_all[i*DATA_W +: DATA_W] = d;
            // A same-cycle write delivers the value through the bypass, so the reader need not stall.
            rd_busy_all[i] = busy[a] && !(hit0 || hit1);
        end
    end

    assign bus.rd       = rd_all;
    assign bus.rd_busy  = rd_busy_all;
    assign bus.busy_vec = busy;
endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Directed vector bench for regfile_mp_bypass: default configuration table plus a 64-bit/16-entry/5-port sweep.
module tb_regfile_mp_bypass;
    logic clk  = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_bypass_if #(.DATA_W(32), .ADDR_W(5), .NRD(3)) b0 ();
    regfile_mp_bypass_if #(.DATA_W(64), .ADDR_W(4), .NRD(5)) b1 ();

    regfile_mp_bypass #(.DATA_W(32), .ADDR_W(5), .NRD(3), .ZERO_R0(1)) dut0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (b0.slave)
    );

    regfile_mp_bypass #(.DATA_W(64), .ADDR_W(4), .NRD(5), .ZERO_R0(0)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (b1.slave)
    );

    typedef struct {
        logic        rst;
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0, ra1, ra2;
        logic        sb_set;
        logic [4:0]  sb_addr;
        logic        chk;
        logic [31:0] e0, e1, e2;
        logic [2:0]  eb;
        logic [31:0] ebv;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   passed = 0;

    task automatic add(input logic rst, input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic sb_set, input logic [4:0] sb_addr, input logic chk,
                       input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                       input logic [2:0] eb, input logic [31:0] ebv);
        vec_t v;
        v.rst = rst; v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
        v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
        v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2;
        v.sb_set = sb_set; v.sb_addr = sb_addr; v.chk = chk;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.eb = eb; v.ebv = ebv;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive1(input logic we0, input logic [3:0] wa0, input logic [63:0] wd0,
                          input logic we1, input logic [3:0] wa1, input logic [63:0] wd1,
                          input logic [19:0] ra, input logic sb_set, input logic [3:0] sb_addr);
        b1.we0 = we0; b1.wa0 = wa0; b1.wd0 = wd0;
        b1.we1 = we1; b1.wa1 = wa1; b1.wd1 = wd1;
        b1.ra = ra; b1.sb_set = sb_set; b1.sb_addr = sb_addr;
    endtask

    task automatic check1(input string tag, input logic [63:0] e0, input logic [63:0] e1,
                          input logic [63:0] e2, input logic [63:0] e3, input logic [63:0] e4,
                          input logic [4:0] eb, input logic [15:0] ebv);
        logic [63:0] e [5];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
        for (int p = 0; p < 5; p++) begin
            chk($sformatf("%s rd%0d", tag, p), 128'(b1.rd[p*64 +: 64]), 128'(e[p]));
        end
        chk({tag, " rd_busy"}, 128'(b1.rd_busy), 128'(eb));
        chk({tag, " busy_vec"}, 128'(b1.busy_vec), 128'(ebv));
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] CF = 32'h00C0FFEE;
    localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;

    initial begin
        //  rst we0 wa0 wd0        we1 wa1 wd1       ra0 ra1 ra2 sb sba chk e0      e1      e2      eb      ebv
        add(1, 1, 5,  32'h1,       0, 0,  0,         0,  0,  0,  1, 3,  0,  0,      0,      0,      3'b000, 0);
        add(0, 0, 0,  0,           0, 0,  0,         3,  17, 31, 0, 0,  1,  0,      0,      0,      3'b000, 0);
        add(0, 0, 0,  0,           0, 0,  0,         5,  0,  31, 0, 0,  1,  0,      0,      0,      3'b000, 0);
        add(0, 1, 5,  DB,          0, 0,  0,         3,  5,  5,  0, 0,  1,  0,      DB,     DB,     3'b000, 0);
        add(0, 0, 0,  0,           0, 0,  0,         5,  3,  0,  0, 0,  1,  DB,     0,      0,      3'b000, 0);
        add(0, 1, 9,  32'h11,      1, 9,  32'h22,    9,  9,  5,  0, 0,  1,  32'h22, 32'h22, DB,     3'b000, 0);
        add(0, 1, 0,  32'hFFFF,    0, 0,  0,         9,  0,  0,  0, 0,  1,  32'h22, 0,      0,      3'b000, 0);
        add(0, 0, 0,  0,           0, 0,  0,         0,  9,  1,  1, 12, 1,  0,      32'h22, 0,      3'b000, 0);
        add(0, 0, 0,  0,           0, 0,  0,         12, 0,  9,  1, 0,  1,  0,      0,      32'h22, 3'b001, 32'h1000);
        add(0, 1, 12, CF,          0, 0,  0,         12, 12, 0,  1, 7,  1,  CF,     CF,     0,      3'b000, 32'h1000);
        add(0, 0, 0,  0,           0, 0,  0,         12, 7,  0,  0, 0,  1,  CF,     0,      0,      3'b010, 32'h80);
        add(0, 0, 0,  0,           1, 7,  32'h77,    7,  7,  12, 1, 7,  1,  32'h77, 32'h77, CF,     3'b000, 32'h80);
        add(0, 1, 21, 32'h1234,    1, 20, 32'hABCD,  7,  0,  12, 0, 0,  1,  32'h77, 0,      CF,     3'b001, 32'h80);
        add(0, 0, 0,  0,           0, 0,  0,         20, 21, 7,  0, 0,  1,  32'hABCD, 32'h1234, 32'h77, 3'b100, 32'h80);
        add(1, 1, 5,  32'h5555,    0, 0,  0,         5,  9,  7,  1, 9,  0,  0,      0,      0,      3'b000, 0);
        add(0, 0, 0,  0,           0, 0,  0,         5,  9,  7,  0, 0,  1,  0,      0,      0,      3'b000, 0);
        add(0, 0, 0,  0,           0, 0,  0,         20, 12, 21, 0, 0,  1,  0,      0,      0,      3'b000, 0);

        drive1(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < vq.size(); k++) begin
            rst0       = vq[k].rst;
            b0.we0     = vq[k].we0;  b0.wa0 = vq[k].wa0;  b0.wd0 = vq[k].wd0;
            b0.we1     = vq[k].we1;  b0.wa1 = vq[k].wa1;  b0.wd1 = vq[k].wd1;
            b0.ra      = {vq[k].ra2, vq[k].ra1, vq[k].ra0};
            b0.sb_set  = vq[k].sb_set; b0.sb_addr = vq[k].sb_addr;
            #4;
            if (vq[k].chk) begin
                chk($sformatf("v%0d rd0", k), 128'(b0.rd[31:0]), 128'(vq[k].e0));
                chk($sformatf("v%0d rd1", k), 128'(b0.rd[63:32]), 128'(vq[k].e1));
                chk($sformatf("v%0d rd2", k), 128'(b0.rd[95:64]), 128'(vq[k].e2));
                chk($sformatf("v%0d rd_busy", k), 128'(b0.rd_busy), 128'(vq[k].eb));
                chk($sformatf("v%0d busy_vec", k), 128'(b0.busy_vec), 128'(vq[k].ebv));
            end
            @(posedge clk);
            #1;
        end

        // Sweep configuration: register 0 is an ordinary, writable, busy-capable register.
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        drive1(1, 4'd0, D0, 0, 0, 0, {4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 1, 4'd0);
        #4; check1("swA", D0, D0, D0, D0, D0, 5'b00000, 16'h0000);
        @(posedge clk); #1;
        drive1(0, 0, 0, 1, 4'd15, D1, {4'd0, 4'd15, 4'd3, 4'd15, 4'd0}, 0, 0);
        #4; check1("swB", D0, D1, 0, D1, D0, 5'b10001, 16'h0001);
        @(posedge clk); #1;
        drive1(0, 0, 0, 0, 0, 0, {4'd0, 4'd1, 4'd15, 4'd0, 4'd15}, 0, 0);
        #4; check1("swC", D1, D0, D1, 0, D0, 5'b10010, 16'h0001);
        @(posedge clk); #1;
        drive1(1, 4'd0, D2, 0, 0, 0, {4'd0, 4'd1, 4'd15, 4'd0, 4'd15}, 0, 0);
        #4; check1("swD", D1, D2, D1, 0, D2, 5'b00000, 16'h0001);
        @(posedge clk); #1;
        drive1(0, 0, 0, 0, 0, 0, {4'd15, 4'd0, 4'd3, 4'd1, 4'd0}, 0, 0);
        #4; check1("swE", D2, 0, 0, D2, D1, 5'b00000, 16'h0000);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/regfile_mp_bypass.md
Name: regfile_mp_bypass

Overview:
Parametrised multi-port register file, the next generation of the 32x32 three-read-port register bank. It adds a configurable data width, depth and read-port count, two write ports with fixed priority, and same-cycle write-to-read bypass. It also carries a per-register busy scoreboard so the decode stage can detect pending producers. It sits between decode (read addresses, scoreboard set) and writeback (two retire lanes).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
NRD, 3, number of read ports
ZERO_R0, 1, 1 = register 0 reads as zero, ignores writes and is never busy

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
we0  in  1  write enable, lane 0
wa0  in  ADDR_W  write address, lane 0
wd0  in  DATA_W  write data, lane 0
we1  in  1  write enable, lane 1 (higher priority)
wa1  in  ADDR_W  write address, lane 1
wd1  in  DATA_W  write data, lane 1
ra  in  NRD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
rd  out  NRD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
rd_busy  out  NRD  port i address has a pending producer
sb_set  in  1  mark register sb_addr busy
sb_addr  in  ADDR_W  register being claimed by a newly issued producer
busy_vec  out  DEPTH  full scoreboard, bit n = register n busy

Behaviour:
- One clock. Reset is synchronous and active-high; clock port is clk, reset port is reset.
- Reset (sampled high at a clk edge):
  - all registers load 0 and all busy bits load 0;
  - writes and sb_set in that cycle are discarded;
  - once registers are 0, rd outputs read 0 (combinational);
  - reset asserted mid-operation has the same effect.
- Storage writes take effect at the rising edge:
  - if we0 and we1 are both set with wa0 == wa1, lane 1 data is stored;
  - with ZERO_R0=1, writes to address 0 are dropped.
- Reads are combinational, with zero added latency. For each port i, rd_i is selected by priority:
  1. ZERO_R0=1 and ra_i == 0: 0.
  2. we1 and wa1 == ra_i: wd1 (bypass).
  3. we0 and wa0 == ra_i: wd0 (bypass).
  4. Otherwise: stored register value.
- All NRD ports are independent; any number may share an address.
- Scoreboard, evaluated per register n at each edge:
  - clr_n = (we0 and wa0 == n) or (we1 and wa1 == n);
  - set_n = sb_set and sb_addr == n;
  - next busy_n = set_n or (busy_n and not clr_n). Set wins over a same-cycle clear, because a new producer was issued.
  - With ZERO_R0=1, busy_0 is held at 0 and sb_set to address 0 is ignored.
- rd_busy_i = busy[ra_i] and not (write hit on ra_i this cycle). A same-cycle write means the bypassed data is valid. The same cycle's sb_set does not affect rd_busy; it shows the next cycle.
- busy_vec reflects registered state only, with no bypass.
- No other state exists and there are no illegal states. An out-of-range address cannot occur because DEPTH = 2**ADDR_W.

Test Plan:
- Reset then read: hold reset one cycle, then ra = {3, 17, 31} -> rd = all 0, rd_busy = 000, busy_vec = 0.
- Write/read back: we0, wa0=5, wd0=0xDEADBEEF for one cycle, then ra0=5 -> rd0 = 0xDEADBEEF. Same-cycle ra1=5 during the write -> rd1 = 0xDEADBEEF via bypass.
- Lane collision: we0/we1 both to reg 9 with wd0=0x11, wd1=0x22 -> same-cycle rd = 0x22 and stored value = 0x22. Write to reg 0 with 0xFFFF -> reads 0.
- Scoreboard: sb_set reg 12 -> next cycle busy_vec[12]=1 and rd_busy=1 for ra=12. Write lane 0 to reg 12 -> rd_busy=0 that cycle, busy_vec[12]=0 the next.
- Set/clear race: busy_vec[7]=1, then sb_set reg 7 plus we1 to reg 7 the same cycle -> busy_vec[7] stays 1 and the data is stored.
- Parameter sweep: DATA_W=64, ADDR_W=4, NRD=5, ZERO_R0=0 -> reg 0 is writable and can be busy; all 5 ports read independently.
